// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction fetch stage: PC, imem handshake, IR, redirect/drain (optional FETCH_PERF_CNT_EN perf counters)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opCode,
    output logic [5:0]  funct,
    output logic [31:0] pc_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic [31:0] target;
    logic        accept;
    logic        outstanding_redirect;
    logic        unused_target_lsbs;

    // Redirect targets are always word aligned; the low bits are dropped.
    assign target             = {branch_target[31:2], 2'b00};
    assign unused_target_lsbs = ^branch_target[1:0];

    // Next state and request generation; request never depends on imem_ready.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = !(stall && ir_valid);
                if (outstanding_redirect) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (imem_ready) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    assign accept               = (state == FETCH) && imem_req && imem_ready && !branch_en;
    assign outstanding_redirect = (state == FETCH) && branch_en && imem_req && !imem_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Architectural PC: redirect wins, otherwise advance on every accepted word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (branch_en) begin
            pc <= target;
        end else if (accept) begin
            pc <= pc + 32'd4;
        end
    end

    // Address of the request left in flight by a redirect, replayed until memory answers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_addr <= 32'h0;
        end else if (outstanding_redirect) begin
            drain_addr <= pc;
        end
    end

    // Instruction register: flush on redirect, fill on accept, empty on consume.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir       <= 32'h0;
            ir_pc    <= 32'h0;
            ir_valid <= 1'b0;
        end else if (branch_en) begin
            ir_valid <= 1'b0;
        end else if (accept) begin
            ir       <= imem_rdata;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
        end else if (ir_valid && !stall) begin
            ir_valid <= 1'b0;
        end
    end

    assign instr_valid = ir_valid;
    assign instr       = ir_valid ? ir : 32'h0;
    assign opCode      = instr[31:26];
    assign funct       = instr[5:0];
    assign pc_out      = ir_pc;

`ifdef FETCH_PERF_CNT_EN
    // Free-running wrap-around counters of accepted fetches and stalled cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (accept) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stall && ir_valid) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a behavioural fetch model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opCode;
    logic [5:0]  funct;
    logic [31:0] pc_out;

    logic        imem_req_hi;
    logic [31:0] imem_addr_hi;
    logic [31:0] imem_rdata_hi;
    logic        instr_valid_hi;
    logic [31:0] instr_hi;
    logic [5:0]  opcode_hi;
    logic [5:0]  funct_hi;
    logic [31:0] pc_out_hi;
    logic        one = 1'b1;
    logic        zero = 1'b0;
    logic [31:0] zero32 = 32'h0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
    logic [31:0] fetch_count_hi;
    logic [31:0] stall_count_hi;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // Instruction memory content: every word is tagged with its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C21_0000;
    endfunction

    assign imem_rdata    = mem_word(imem_addr);
    assign imem_rdata_hi = mem_word(imem_addr_hi);

    fetch_unit dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .branch_en(branch_en), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr(instr), .opCode(opCode), .funct(funct),
        .pc_out(pc_out)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req_hi), .imem_addr(imem_addr_hi),
        .imem_ready(one), .imem_rdata(imem_rdata_hi),
        .stall(zero), .branch_en(zero), .branch_target(zero32),
        .instr_valid(instr_valid_hi), .instr(instr_hi), .opCode(opcode_hi), .funct(funct_hi),
        .pc_out(pc_out_hi)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count_hi), .stall_count(stall_count_hi)
`endif
    );

    // Behavioural model: phase 0 = boot, 1 = fetching, 2 = waiting out a stale request.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_stale;
    logic        m_valid;
    logic [31:0] m_word;
    logic [31:0] m_word_pc;
    logic [31:0] m_fetches;
    logic [31:0] m_stalls;

    function automatic logic exp_req();
        if (m_phase == 0) return 1'b0;
        if (m_phase == 2) return 1'b1;
        return !(stall && m_valid);
    endfunction

    function automatic logic [31:0] exp_addr();
        return (m_phase == 2) ? m_stale : m_pc;
    endfunction

    function automatic logic [31:0] exp_instr();
        return m_valid ? m_word : 32'h0;
    endfunction

    // Model advances one cycle per rising edge from the same inputs the DUT sees.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase   <= 0;
            m_pc      <= 32'h0;
            m_stale   <= 32'h0;
            m_valid   <= 1'b0;
            m_word    <= 32'h0;
            m_word_pc <= 32'h0;
            m_fetches <= 32'h0;
            m_stalls  <= 32'h0;
        end else begin
            if (stall && m_valid) m_stalls <= m_stalls + 1;
            if (branch_en) begin
                m_valid <= 1'b0;
                m_pc    <= branch_target & 32'hFFFF_FFFC;
                if (m_phase == 0) m_phase <= 1;
                else if (m_phase == 2) begin
                    if (imem_ready) m_phase <= 1;
                end else if (exp_req() && !imem_ready) begin
                    m_phase <= 2;
                    m_stale <= m_pc;
                end
            end else if (m_phase == 0) begin
                m_phase <= 1;
            end else if (m_phase == 2) begin
                if (imem_ready) m_phase <= 1;
            end else if (exp_req() && imem_ready) begin
                m_word    <= mem_word(m_pc);
                m_word_pc <= m_pc;
                m_pc      <= m_pc + 32'd4;
                m_valid   <= 1'b1;
                m_fetches <= m_fetches + 1;
            end else if (m_valid && !stall) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_model();
        logic [31:0] e;
        e = exp_instr();
        chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req()});
        chk("imem_addr", imem_addr, exp_addr());
        chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
        chk("instr", instr, e);
        chk("opCode", {26'h0, opCode}, {26'h0, e[31:26]});
        chk("funct", {26'h0, funct}, {26'h0, e[5:0]});
        chk("pc_out", pc_out, m_word_pc);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, m_fetches);
        chk("stall_count", stall_count, m_stalls);
`endif
    endtask

    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        imem_ready    = r;
        stall         = s;
        branch_en     = b;
        branch_target = t;
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        reset_n = 1'b0;
        imem_ready = 1'b0;
        stall = 1'b0;
        branch_en = 1'b0;
        branch_target = 32'h0;
        @(negedge clk);
        chk("rst imem_req", {31'h0, imem_req}, 32'h0);
        chk("rst imem_addr", imem_addr, 32'h0);
        chk("rst instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst instr", instr, 32'h0);
        chk("rst pc_out", pc_out, 32'h0);
        chk("rst hi imem_addr", imem_addr_hi, 32'hFFFF_FFF8);
        reset_n = 1'b1;
        #1;
        chk("boot imem_req", {31'h0, imem_req}, 32'h0);

        // Zero-wait memory after reset release, plus the high RESET_PC instance.
        step(1, 0, 0, 0);
        chk("zw addr0", imem_addr, 32'h0);
        chk("zw req", {31'h0, imem_req}, 32'h1);
        chk("hi addr0", imem_addr_hi, 32'hFFFF_FFF8);
        step(1, 0, 0, 0);
        chk("zw addr1", imem_addr, 32'h4);
        chk("zw pc_out0", pc_out, 32'h0);
        chk("zw instr0", instr, 32'h8C21_0000);
        chk("hi addr1", imem_addr_hi, 32'hFFFF_FFFC);
        chk("hi pc_out0", pc_out_hi, 32'hFFFF_FFF8);
        step(1, 0, 0, 0);
        chk("zw addr2", imem_addr, 32'h8);
        chk("zw pc_out1", pc_out, 32'h4);
        chk("hi addr2", imem_addr_hi, 32'h0);
        chk("hi pc_out1", pc_out_hi, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        chk("hi pc_out2", pc_out_hi, 32'h0);
        chk("hi instr2", instr_hi, 32'h8C21_0000);
        chk("zw pc_out2", pc_out, 32'h8);
`ifdef FETCH_PERF_CNT_EN
        chk("hi fetch_count", fetch_count_hi, 32'd3);
`endif

        // Stall with a valid IR for three cycles, then resume without skipping.
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            chk("stall req", {31'h0, imem_req}, 32'h0);
            chk("stall pc_out", pc_out, 32'h8);
        end
        step(1, 0, 0, 0);
        chk("resume pc_out", pc_out, 32'hC);
        step(1, 0, 0, 0);

        // Wait-state memory: ready every third cycle.
        for (int i = 0; i < 9; i++) step((i % 3) == 2, 0, 0, 0);

        // Redirect while a request is outstanding, drain the stale word.
        step(0, 0, 1, 32'h0000_0103);
        chk("br flush valid", {31'h0, instr_valid}, 32'h0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("drain target addr", imem_addr, 32'h100);
        chk("drain valid", {31'h0, instr_valid}, 32'h0);
        step(1, 0, 0, 0);
        chk("target pc_out", pc_out, 32'h100);

        // Second redirect arriving during the drain.
        step(0, 0, 1, 32'h200);
        step(0, 0, 1, 32'h300);
        step(1, 0, 0, 0);
        chk("redrain addr", imem_addr, 32'h300);
        step(1, 0, 0, 0);

        // Redirect together with ready and stall: no drain.
        step(1, 1, 1, 32'h40);
        chk("br+stall valid", {31'h0, instr_valid}, 32'h0);
        chk("br+stall addr", imem_addr, 32'h40);
        step(1, 1, 1, 32'h80);
        chk("br+ready addr", imem_addr, 32'h80);
        chk("br+ready req", {31'h0, imem_req}, 32'h1);
        step(1, 0, 0, 0);

        // Redirect near the top of the address space to exercise wrap.
        step(1, 0, 1, 32'hFFFF_FFF8);
        chk("wrap addr0", imem_addr, 32'hFFFF_FFF8);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("wrap addr2", imem_addr, 32'h0);
        step(1, 0, 0, 0);

        // Asynchronous reset in the middle of an outstanding fetch.
        step(0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async req", {31'h0, imem_req}, 32'h0);
        chk("async addr", imem_addr, 32'h0);
        chk("async valid", {31'h0, instr_valid}, 32'h0);
        chk("async pc_out", pc_out, 32'h0);
        step(1, 0, 0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-issue MIPS datapath. Holds the program counter, runs a request/ready handshake with instruction memory and latches each returned word into an instruction register (IR). The IR drives `opCode` and `funct` into the control decoder directly downstream. Supports downstream stall and branch/jump redirect with flush.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address, equal to the current PC.
- `imem_ready` in 1: memory accepts the request, with `imem_rdata` valid in the same cycle.
- `imem_rdata` in 32: fetched instruction word.
- `stall` in 1: downstream cannot consume the IR this cycle.
- `branch_en` in 1: redirect request, one-cycle pulse.
- `branch_target` in 32: redirect address; bits [1:0] are ignored and forced to 0.
- `instr_valid` out 1: the IR holds a valid instruction.
- `instr` out 32: IR contents when `instr_valid` is 1, otherwise 32'h0 (nop).
- `opCode` out 6: `instr[31:26]`.
- `funct` out 6: `instr[5:0]`.
- `pc_out` out 32: address of the instruction in the IR.

## Operation
- States:
  - BOOT: one cycle after reset release; no request is issued.
  - FETCH: normal fetching.
  - DRAIN: discards an outstanding request after a redirect.
- BOOT → FETCH unconditionally.
- In FETCH, `imem_req` = !(`stall` && `instr_valid`). `imem_addr` = PC and stays stable while `imem_req` is high and `imem_ready` is low.
- Accept: `imem_req` && `imem_ready` && !`branch_en`.
  - IR ← `imem_rdata`; `pc_out` ← PC; PC ← PC+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0); `instr_valid` ← 1.
- Consume: `instr_valid` && !`stall`. If a consume occurs with no accept in the same cycle, `instr_valid` ← 0.
- Stall with `instr_valid`: the IR and `pc_out` hold their values and no request is issued.
- Stall without `instr_valid`: fetching continues and fills the IR.
- Redirect (`branch_en`=1) overrides `stall`:
  - `instr_valid` ← 0 (flush) and PC ← {`branch_target`[31:2], 2'b00}.
  - If `imem_req` is high and `imem_ready` is low, the request is outstanding: go to DRAIN.
  - If `imem_ready` is high in the same cycle, the returned data is discarded and the state stays FETCH.
  - If no request is pending, the state stays FETCH.
- DRAIN: holds `imem_req`=1 with the old address. On `imem_ready`, the data is discarded and the state goes to FETCH at the new PC.
- A further `branch_en` during DRAIN updates PC only; the state remains DRAIN.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`, state=BOOT.
  - `instr_valid`=0, `instr`=0, `opCode`=0, `funct`=0, `pc_out`=0.
  - Perf counters (if present)=0.
- Reset assertion mid-fetch aborts immediately (asynchronous). Any in-flight memory response is ignored.
- First request: `imem_req` rises on the second clock edge after reset release.
- Latency: IR updates on the edge of the cycle where `imem_ready` is high. The instruction is visible on `opCode`/`funct` the following cycle.
- Throughput: with zero-wait memory and no stall, one instruction per cycle.
- Redirect: the target is fetched in the cycle after `branch_en` (FETCH). In DRAIN, it is fetched in the cycle after the drained `imem_ready`. `instr_valid` is 0 in the cycle after `branch_en`.
- `imem_req`, `imem_addr` and the `instr` outputs derive from registers and current `stall`/`instr_valid` only. There is no combinational path from `imem_ready` to `imem_req`.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds outputs `fetch_count` out 32 (incremented per accept) and `stall_count` out 32 (incremented per cycle with `stall` && `instr_valid`).
  - Both counters wrap at 2^32 and reset to 0.
- `FETCH_PERF_CNT_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset release, `imem_ready` tied 1, memory returns addr-tagged words:
  - `imem_addr` sequence is 0, 4, 8 starting on the second edge.
  - `instr_valid` is continuous; `pc_out` lags `imem_addr` by one cycle.
- Stall held 3 cycles with `instr_valid`=1:
  - `imem_req`=0 for 3 cycles; `instr`/`pc_out` constant.
  - Fetching resumes at the next PC with no skipped or duplicated word.
- Wait-state memory (`imem_ready` high every 3rd cycle): `imem_addr` stays stable while waiting, and each word is captured exactly once.
- `branch_en` with `branch_target`=32'h0000_0103 while a request is outstanding:
  - Enters DRAIN; the old word is discarded on `imem_ready`.
  - The next `imem_addr` is 32'h0000_0100; `instr_valid` is 0 until that word arrives.
- `branch_en` in the same cycle as `imem_ready` and `stall`:
  - Returned data is discarded and `instr_valid` becomes 0.
  - Next fetch is at the target; no DRAIN.
- `RESET_PC`=32'hFFFF_FFF8, zero-wait memory: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. With `FETCH_PERF_CNT_EN`, `fetch_count`=3 after three accepts.
